// File: rtl/match_event_logger.sv
// Counts 101-detector matches, timestamps each with the stream bit index and
// queues timestamps in a show-ahead FIFO. Optional MATCH_EVENT_LOGGER_GAP_EN adds gap tracking.
module match_event_logger #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             z,
  input  logic             rd_en,
  output logic [TS_W-1:0]  ts_data,
  output logic             ts_valid,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [TS_W-1:0]  gap
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]     OCC_ONE  = (PW+1)'(1);
  localparam logic [PW:0]     OCC_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0]  bidx_q, bidx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic det, pop, push, is_full, is_empty;

  assign is_full  = (occ_q == OCC_FULL);
  assign is_empty = (occ_q == '0);
  assign det      = en & z;
  assign pop      = rd_en & ~is_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push     = det & (~is_full | pop);

  always_comb begin
    bidx_d     = bidx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    if (en) bidx_d = bidx_q + TS_ONE;
    if (det && count_q != CNT_MAX) count_d = count_q + CNT_ONE;
    if (det && !push) overflow_d = 1'b1;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      bidx_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
    end else begin
      bidx_q     <= bidx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bidx_q;
  end

  assign ts_data  = is_empty ? '0 : mem_q[rptr_q];
  assign ts_valid = ~is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef MATCH_EVENT_LOGGER_GAP_EN
  logic [TS_W-1:0] last_ts_q, last_ts_d, gap_q, gap_d;
  logic            seen_q, seen_d;

  // Modular subtraction gives the right distance across a bidx wrap.
  always_comb begin
    last_ts_d = last_ts_q;
    gap_d     = gap_q;
    seen_d    = seen_q;
    if (det) begin
      last_ts_d = bidx_q;
      seen_d    = 1'b1;
      if (seen_q) gap_d = bidx_q - last_ts_q;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      last_ts_q <= '0;
      gap_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      last_ts_q <= last_ts_d;
      gap_q     <= gap_d;
      seen_q    <= seen_d;
    end
  end

  assign gap = gap_q;
`else
  assign gap = '0;
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Directed self-checking bench for match_event_logger: a default-sized instance
// and a narrow one (CNT_W=3, TS_W=4) for saturation and wrap cases.
module tb_match_event_logger;

`ifdef MATCH_EVENT_LOGGER_GAP_EN
  localparam bit GapOn = 1'b1;
`else
  localparam bit GapOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clearN = 1'b0;
  logic        enA = 1'b0, zA = 1'b0, rdA = 1'b0;
  logic        enB = 1'b0, zB = 1'b0, rdB = 1'b0;

  logic [15:0] tsDataA, gapA;
  logic        tsValidA, fullA, overflowA;
  logic [7:0]  countA;
  logic [3:0]  tsDataB, gapB;
  logic        tsValidB, fullB, overflowB;
  logic [2:0]  countB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  match_event_logger #(.CNT_W(8), .TS_W(16), .DEPTH(4)) dutA (
    .clk(clk), .clear_n(clearN), .en(enA), .z(zA), .rd_en(rdA),
    .ts_data(tsDataA), .ts_valid(tsValidA), .full(fullA),
    .count(countA), .overflow(overflowA), .gap(gapA)
  );

  match_event_logger #(.CNT_W(3), .TS_W(4), .DEPTH(4)) dutB (
    .clk(clk), .clear_n(clearN), .en(enB), .z(zB), .rd_en(rdB),
    .ts_data(tsDataB), .ts_valid(tsValidB), .full(fullB),
    .count(countB), .overflow(overflowB), .gap(gapB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs for both instances, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic eA, input logic zzA, input logic rA,
                               input logic eB, input logic zzB, input logic rB);
    enA = eA; zA = zzA; rdA = rA;
    enB = eB; zB = zzB; rdB = rB;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset low between edges; returns before the next edge.
  task automatic applyReset();
    enA = 0; zA = 0; rdA = 0; enB = 0; zB = 0; rdB = 0;
    clearN = 1'b0;
    #2;
    clearN = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    checkOutput("rst_count", countA, 0);
    checkOutput("rst_valid", tsValidA, 0);
    checkOutput("rst_full", fullA, 0);
    checkOutput("rst_ovf", overflowA, 0);
    checkOutput("rst_data", tsDataA, 0);
    checkOutput("rst_gap", gapA, 0);
    @(posedge clk); #1;
    applyReset();

    // Base capture: detections at 3, 5, 10
    for (int i = 0; i <= 10; i++)
      applyStimulus(1, (i == 3 || i == 5 || i == 10), 0, 0, 0, 0);
    checkOutput("base_count", countA, 3);
    checkOutput("base_valid", tsValidA, 1);
    checkOutput("base_full", fullA, 0);
    checkOutput("base_ovf", overflowA, 0);
    checkOutput("base_head0", tsDataA, 3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("base_head1", tsDataA, 5);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("base_head2", tsDataA, 10);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("base_empty", tsValidA, 0);
    checkOutput("base_empty_data", tsDataA, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("base_rd_empty", tsValidA, 0);

    // Overflow: detections at 1..5
    applyReset();
    for (int i = 0; i <= 5; i++) begin
      applyStimulus(1, (i >= 1), 0, 0, 0, 0);
      if (i == 4) begin
        checkOutput("ovf_full4", fullA, 1);
        checkOutput("ovf_notyet", overflowA, 0);
      end
    end
    checkOutput("ovf_set", overflowA, 1);
    checkOutput("ovf_count", countA, 5);
    checkOutput("ovf_full5", fullA, 1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("ovf_drain%0d", k), tsDataA, k);
      applyStimulus(0, 0, 1, 0, 0, 0);
    end
    checkOutput("ovf_drained", tsValidA, 0);
    checkOutput("ovf_sticky", overflowA, 1);

    // Full with concurrent pop at index 20
    applyReset();
    for (int i = 0; i <= 20; i++)
      applyStimulus(1, (i >= 16), (i == 20), 0, 0, 0);
    checkOutput("cpop_ovf", overflowA, 0);
    checkOutput("cpop_full", fullA, 1);
    checkOutput("cpop_count", countA, 5);
    for (int k = 17; k <= 20; k++) begin
      checkOutput($sformatf("cpop_drain%0d", k), tsDataA, k);
      applyStimulus(0, 0, 1, 0, 0, 0);
    end
    checkOutput("cpop_empty", tsValidA, 0);

    // Reset mid-stream with three entries queued and overflow set
    applyReset();
    for (int i = 0; i <= 4; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("mid_pre_ovf", overflowA, 1);
    checkOutput("mid_pre_head", tsDataA, 2);
    clearN = 1'b0;
    #2;
    checkOutput("mid_count", countA, 0);
    checkOutput("mid_valid", tsValidA, 0);
    checkOutput("mid_full", fullA, 0);
    checkOutput("mid_ovf", overflowA, 0);
    checkOutput("mid_data", tsDataA, 0);
    checkOutput("mid_gap", gapA, 0);
    clearN = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("mid_first_ts", tsDataA, 0);
    checkOutput("mid_first_cnt", countA, 1);

    // Gating and saturation on the narrow instance
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("gate_count", countB, 0);
    checkOutput("gate_valid", tsValidB, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 1);
      if (i == 0) checkOutput("gate_first_ts", tsDataB, 0);
    end
    checkOutput("sat_count", countB, 7);
    checkOutput("sat_head", tsDataB, 8);
    checkOutput("sat_ovf", overflowB, 0);

    // Gap tracking with wrap on the narrow instance
    applyReset();
    for (int i = 0; i <= 5; i++) begin
      applyStimulus(0, 0, 0, 1, (i == 3 || i == 5), 0);
      if (i == 3) checkOutput("gap_first", gapB, 0);
    end
    checkOutput("gap_3_5", gapB, GapOn ? 2 : 0);
    for (int i = 6; i <= 17; i++) begin
      applyStimulus(0, 0, 0, 1, ((i % 16) == 14 || i == 17), 0);
      if (i == 14) checkOutput("gap_5_14", gapB, GapOn ? 9 : 0);
    end
    checkOutput("gap_wrap", gapB, GapOn ? 3 : 0);
    checkOutput("gap_fifo_full", fullB, 1);
    checkOutput("gap_fifo_head", tsDataB, 3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
